// File: rtl/id_ex_stage_if.sv
// Bundle of the decode stage's fetch, register-file, write-back and ID/EX signals.
// The slave modport is the stage itself; master is whatever surrounds it.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;
  logic              id_stall;

  logic [ADDR_W-1:0] read_addr_1;
  logic [ADDR_W-1:0] read_addr_2;
  logic [DATA_W-1:0] data_out_1;
  logic [DATA_W-1:0] data_out_2;

  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_write_addr;
  logic [DATA_W-1:0] wb_write_data;

  logic              ex_hold;
  logic              flush;

  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [31:0]       ex_imm;
  logic [ADDR_W-1:0] ex_rs;
  logic [ADDR_W-1:0] ex_rt;
  logic [ADDR_W-1:0] ex_dest;
  logic [2:0]        ex_alu_op;
  logic              ex_alu_src;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_branch;
  logic              ex_illegal;

  modport slave (
    input  if_valid, if_instr, if_pc,
    output id_stall,
    output read_addr_1, read_addr_2,
    input  data_out_1, data_out_2,
    input  wb_reg_write, wb_write_addr, wb_write_data,
    input  ex_hold, flush,
    output ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
    output ex_rs, ex_rt, ex_dest, ex_alu_op,
    output ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal
  );

  modport master (
    output if_valid, if_instr, if_pc,
    input  id_stall,
    input  read_addr_1, read_addr_2,
    output data_out_1, data_out_2,
    output wb_reg_write, wb_write_addr, wb_write_data,
    output ex_hold, flush,
    input  ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
    input  ex_rs, ex_rt, ex_dest, ex_alu_op,
    input  ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS instruction decode with write-back bypass, load-use stall detection
// and the ID/EX pipeline register.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [31:0]       imm;

  assign opcode = bus.if_instr[31:26];
  assign funct  = bus.if_instr[5:0];
  assign rs     = bus.if_instr[25:21];
  assign rt     = bus.if_instr[20:16];
  assign rd     = bus.if_instr[15:11];
  assign imm    = {{16{bus.if_instr[15]}}, bus.if_instr[15:0]};

  assign bus.read_addr_1 = rs;
  assign bus.read_addr_2 = rt;

  alu_op_e           dec_alu_op;
  logic              dec_alu_src;
  logic              dec_reg_write;
  logic              dec_mem_read;
  logic              dec_mem_write;
  logic              dec_branch;
  logic              dec_illegal;
  logic              dec_uses_rt;
  logic [ADDR_W-1:0] dec_dest;

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    dec_alu_op    = ALU_ADD;
    dec_alu_src   = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_illegal   = 1'b0;
    dec_dest      = '0;
    dec_uses_rt   = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        dec_uses_rt = 1'b1;
        dec_dest      = rd;
        dec_reg_write = 1'b1;
        unique case (funct)
          6'h20:   dec_alu_op = ALU_ADD;
          6'h22:   dec_alu_op = ALU_SUB;
          6'h24:   dec_alu_op = ALU_AND;
          6'h25:   dec_alu_op = ALU_OR;
          6'h2A:   dec_alu_op = ALU_SLT;
          default: begin
            dec_dest      = '0;
            dec_reg_write = 1'b0;
            dec_illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        dec_alu_src   = 1'b1;
        dec_dest      = rt;
        dec_reg_write = 1'b1;
      end
      OP_LW: begin
        dec_alu_src   = 1'b1;
        dec_dest      = rt;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
      end
      OP_SW: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        dec_uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        dec_alu_op  = ALU_SUB;
        dec_branch  = 1'b1;
        dec_uses_rt = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Register 0 reads as zero; a same-cycle write-back beats the stale file read.
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  always_comb begin
    rs_data = bus.data_out_1;
    if (rs == '0)
      rs_data = '0;
    else if (bus.wb_reg_write && bus.wb_write_addr == rs)
      rs_data = bus.wb_write_data;
  end

  always_comb begin
    rt_data = bus.data_out_2;
    if (rt == '0)
      rt_data = '0;
    else if (bus.wb_reg_write && bus.wb_write_addr == rt)
      rt_data = bus.wb_write_data;
  end

  logic hazard;
  assign hazard = bus.ex_valid && bus.ex_mem_read && (bus.ex_dest != '0) &&
                  ((bus.ex_dest == rs) || (dec_uses_rt && bus.ex_dest == rt));

  assign bus.id_stall = bus.if_valid && !bus.flush && (hazard || bus.ex_hold);

  logic wb_hits_ex_rs;
  logic wb_hits_ex_rt;
  assign wb_hits_ex_rs = bus.wb_reg_write && (bus.wb_write_addr != '0) &&
                         (bus.wb_write_addr == bus.ex_rs);
  assign wb_hits_ex_rt = bus.wb_reg_write && (bus.wb_write_addr != '0) &&
                         (bus.wb_write_addr == bus.ex_rt);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_pc        <= '0;
      bus.ex_rs_data   <= '0;
      bus.ex_rt_data   <= '0;
      bus.ex_imm       <= '0;
      bus.ex_rs        <= '0;
      bus.ex_rt        <= '0;
      bus.ex_dest      <= '0;
      bus.ex_alu_op    <= '0;
      bus.ex_alu_src   <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_mem_write <= 1'b0;
      bus.ex_branch    <= 1'b0;
      bus.ex_illegal   <= 1'b0;
    end else if (bus.flush) begin
      bus.ex_valid <= 1'b0;
    end else if (bus.ex_hold) begin
      // Held entry keeps tracking write-backs so it is not stale on release.
      if (wb_hits_ex_rs) bus.ex_rs_data <= bus.wb_write_data;
      if (wb_hits_ex_rt) bus.ex_rt_data <= bus.wb_write_data;
    end else if (hazard) begin
      bus.ex_valid <= 1'b0;
    end else begin
      bus.ex_valid     <= bus.if_valid;
      bus.ex_pc        <= bus.if_pc;
      bus.ex_rs_data   <= rs_data;
      bus.ex_rt_data   <= rt_data;
      bus.ex_imm       <= imm;
      bus.ex_rs        <= rs;
      bus.ex_rt        <= rt;
      bus.ex_dest      <= dec_dest;
      bus.ex_alu_op    <= dec_alu_op;
      bus.ex_alu_src   <= dec_alu_src;
      bus.ex_reg_write <= dec_reg_write;
      bus.ex_mem_read  <= dec_mem_read;
      bus.ex_mem_write <= dec_mem_write;
      bus.ex_branch    <= dec_branch;
      bus.ex_illegal   <= dec_illegal && bus.if_valid;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, decode, bypass, load-use,
// hold refresh, flush priority and illegal-opcode handling.
module tb_id_ex_stage;

  logic clk;
  logic rst_n;

  id_ex_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  id_ex_stage #(.DATA_W(32), .ADDR_W(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int failed;

  // Snapshot of every ex_* output, packed for one-shot comparisons.
  logic [152:0] ex_all;
  assign ex_all = {bus.ex_valid, bus.ex_pc, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm,
                   bus.ex_rs, bus.ex_rt, bus.ex_dest, bus.ex_alu_op,
                   bus.ex_alu_src, bus.ex_reg_write, bus.ex_mem_read,
                   bus.ex_mem_write, bus.ex_branch, bus.ex_illegal};

  // Control flags packed as {alu_src, reg_write, mem_read, mem_write, branch, illegal}.
  logic [5:0] ctl;
  assign ctl = {bus.ex_alu_src, bus.ex_reg_write, bus.ex_mem_read,
                bus.ex_mem_write, bus.ex_branch, bus.ex_illegal};

  localparam logic [31:0] I_ADDI_5_0_M4 = 32'h2005FFFC;
  localparam logic [31:0] I_ADD_3_1_2   = 32'h00221820;
  localparam logic [31:0] I_LW_4_0_1    = 32'h8C240000;
  localparam logic [31:0] I_ADD_6_4_4   = 32'h00843020;
  localparam logic [31:0] I_ADDI_4_0_1  = 32'h20040001;
  localparam logic [31:0] I_SW_2_8_1    = 32'hAC220008;
  localparam logic [31:0] I_BEQ_1_2_M1  = 32'h1022FFFF;
  localparam logic [31:0] I_ILLEGAL     = 32'hFC000000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_valid      = 1'b0;
    bus.if_instr      = 32'h0;
    bus.if_pc         = 32'h0;
    bus.data_out_1    = 32'h0;
    bus.data_out_2    = 32'h0;
    bus.wb_reg_write  = 1'b0;
    bus.wb_write_addr = 5'd0;
    bus.wb_write_data = 32'h0;
    bus.ex_hold       = 1'b0;
    bus.flush         = 1'b0;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    tests++;
    if (ex_all !== '0 || bus.id_stall !== 1'b0) begin
      failed++;
      $display("FAIL reset_initial: ex_all=%h id_stall=%b, want all 0", ex_all, bus.id_stall);
    end
    rst_n = 1'b1;
    tick();
    present(I_ADDI_5_0_M4, 32'h40);
    tick();
    tests++;
    if (bus.ex_valid !== 1'b1) begin
      failed++;
      $display("FAIL reset_pre_valid: ex_valid=%b want 1", bus.ex_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (ex_all !== '0 || bus.id_stall !== 1'b0) begin
      failed++;
      $display("FAIL reset_async: ex_all=%h id_stall=%b, want all 0", ex_all, bus.id_stall);
    end
    tests++;
    if (bus.read_addr_1 !== 5'd0 || bus.read_addr_2 !== 5'd5) begin
      failed++;
      $display("FAIL read_addr: %0d/%0d want 0/5", bus.read_addr_1, bus.read_addr_2);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    present(I_ADDI_5_0_M4, 32'h100);
    bus.data_out_1 = 32'hDEAD_BEEF;
    tick();
    tests++;
    if ({bus.ex_valid, bus.ex_imm, bus.ex_dest, bus.ex_alu_op, ctl, bus.ex_pc} !==
        {1'b1, 32'hFFFF_FFFC, 5'd5, 3'b000, 6'b110000, 32'h100}) begin
      failed++;
      $display("FAIL addi: valid=%b imm=%h dest=%0d op=%b ctl=%b pc=%h want 1 fffffffc 5 000 110000 100",
               bus.ex_valid, bus.ex_imm, bus.ex_dest, bus.ex_alu_op, ctl, bus.ex_pc);
    end
    tests++;
    if (bus.ex_rs_data !== 32'h0) begin
      failed++;
      $display("FAIL addi_r0_zero: ex_rs_data=%h want 0", bus.ex_rs_data);
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    present(I_ADD_3_1_2, 32'h200);
    bus.data_out_1    = 32'h11;
    bus.data_out_2    = 32'h22;
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_addr = 5'd1;
    bus.wb_write_data = 32'hAA;
    tick();
    tests++;
    if ({bus.ex_rs_data, bus.ex_rt_data, bus.ex_dest, bus.ex_alu_op, ctl} !==
        {32'hAA, 32'h22, 5'd3, 3'b000, 6'b010000}) begin
      failed++;
      $display("FAIL bypass_hit: rs=%h rt=%h dest=%0d op=%b ctl=%b want aa 22 3 000 010000",
               bus.ex_rs_data, bus.ex_rt_data, bus.ex_dest, bus.ex_alu_op, ctl);
    end
    bus.wb_write_addr = 5'd0;
    tick();
    tests++;
    if (bus.ex_rs_data !== 32'h11) begin
      failed++;
      $display("FAIL bypass_r0: ex_rs_data=%h want 11", bus.ex_rs_data);
    end
    bus.wb_reg_write  = 1'b0;
    bus.wb_write_addr = 5'd2;
    tick();
    tests++;
    if (bus.ex_rt_data !== 32'h22) begin
      failed++;
      $display("FAIL bypass_we_off: ex_rt_data=%h want 22", bus.ex_rt_data);
    end
    idle_inputs();
  endtask

  task automatic test_rtype_ops();
    logic [5:0] functs [4] = '{6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0] ops    [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    for (int i = 0; i < 4; i++) begin
      present({I_ADD_3_1_2[31:6], functs[i]}, 32'h300);
      tick();
      tests++;
      if (bus.ex_alu_op !== ops[i] || bus.ex_illegal !== 1'b0) begin
        failed++;
        $display("FAIL rtype_funct_%h: op=%b illegal=%b want %b 0",
                 functs[i], bus.ex_alu_op, bus.ex_illegal, ops[i]);
      end
    end
    present(I_SW_2_8_1, 32'h304);
    tick();
    tests++;
    if ({ctl, bus.ex_imm, bus.ex_alu_op} !== {6'b100100, 32'h8, 3'b000}) begin
      failed++;
      $display("FAIL sw: ctl=%b imm=%h op=%b want 100100 8 000", ctl, bus.ex_imm, bus.ex_alu_op);
    end
    present(I_BEQ_1_2_M1, 32'h308);
    tick();
    tests++;
    if ({ctl, bus.ex_imm, bus.ex_alu_op} !== {6'b000010, 32'hFFFF_FFFF, 3'b001}) begin
      failed++;
      $display("FAIL beq: ctl=%b imm=%h op=%b want 000010 ffffffff 001", ctl, bus.ex_imm, bus.ex_alu_op);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    present(I_LW_4_0_1, 32'h400);
    tick();
    tests++;
    if ({bus.ex_valid, bus.ex_mem_read, bus.ex_dest} !== {1'b1, 1'b1, 5'd4}) begin
      failed++;
      $display("FAIL lw_capture: valid=%b mem_read=%b dest=%0d want 1 1 4",
               bus.ex_valid, bus.ex_mem_read, bus.ex_dest);
    end
    present(I_ADD_6_4_4, 32'h404);
    #1;
    tests++;
    if (bus.id_stall !== 1'b1) begin
      failed++;
      $display("FAIL load_use_stall: id_stall=%b want 1", bus.id_stall);
    end
    tick();
    tests++;
    if (bus.ex_valid !== 1'b0 || bus.id_stall !== 1'b0) begin
      failed++;
      $display("FAIL load_use_bubble: ex_valid=%b id_stall=%b want 0 0", bus.ex_valid, bus.id_stall);
    end
    tick();
    tests++;
    if ({bus.ex_valid, bus.ex_rs, bus.ex_dest, bus.ex_pc} !== {1'b1, 5'd4, 5'd6, 32'h404}) begin
      failed++;
      $display("FAIL load_use_resume: valid=%b rs=%0d dest=%0d pc=%h want 1 4 6 404",
               bus.ex_valid, bus.ex_rs, bus.ex_dest, bus.ex_pc);
    end
    present(I_LW_4_0_1, 32'h408);
    tick();
    present(I_ADDI_4_0_1, 32'h40C);
    #1;
    tests++;
    if (bus.id_stall !== 1'b0) begin
      failed++;
      $display("FAIL load_use_no_rt: id_stall=%b want 0 (addi does not read rt)", bus.id_stall);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_hold();
    present(I_ADD_3_1_2, 32'h500);
    bus.data_out_1 = 32'h11;
    bus.data_out_2 = 32'h22;
    tick();
    present(I_ADDI_5_0_M4, 32'h504);
    bus.ex_hold       = 1'b1;
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_addr = 5'd2;
    bus.wb_write_data = 32'h55;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (bus.id_stall !== 1'b1) begin
        failed++;
        $display("FAIL hold_stall_%0d: id_stall=%b want 1", c, bus.id_stall);
      end
      tick();
      tests++;
      if ({bus.ex_valid, bus.ex_pc, bus.ex_rs_data, bus.ex_rt_data, bus.ex_dest, ctl} !==
          {1'b1, 32'h500, 32'h11, 32'h55, 5'd3, 6'b010000}) begin
        failed++;
        $display("FAIL hold_frozen_%0d: valid=%b pc=%h rs=%h rt=%h dest=%0d ctl=%b want 1 500 11 55 3 010000",
                 c, bus.ex_valid, bus.ex_pc, bus.ex_rs_data, bus.ex_rt_data, bus.ex_dest, ctl);
      end
    end
    bus.ex_hold      = 1'b0;
    bus.wb_reg_write = 1'b0;
    tick();
    tests++;
    if ({bus.ex_pc, bus.ex_dest} !== {32'h504, 5'd5}) begin
      failed++;
      $display("FAIL hold_release: pc=%h dest=%0d want 504 5", bus.ex_pc, bus.ex_dest);
    end
    idle_inputs();
  endtask

  task automatic test_flush_illegal();
    present(I_ILLEGAL, 32'h600);
    bus.flush   = 1'b1;
    bus.ex_hold = 1'b1;
    #1;
    tests++;
    if (bus.id_stall !== 1'b0) begin
      failed++;
      $display("FAIL flush_hold_stall: id_stall=%b want 0", bus.id_stall);
    end
    tick();
    tests++;
    if (bus.ex_valid !== 1'b0) begin
      failed++;
      $display("FAIL flush_kill: ex_valid=%b want 0", bus.ex_valid);
    end
    bus.flush   = 1'b0;
    bus.ex_hold = 1'b0;
    tick();
    tests++;
    if ({bus.ex_valid, ctl, bus.ex_pc} !== {1'b1, 6'b000001, 32'h600}) begin
      failed++;
      $display("FAIL illegal: valid=%b ctl=%b pc=%h want 1 000001 600", bus.ex_valid, ctl, bus.ex_pc);
    end
    present(I_LW_4_0_1, 32'h610);
    tick();
    present(I_ADD_6_4_4, 32'h614);
    bus.flush = 1'b1;
    #1;
    tests++;
    if (bus.id_stall !== 1'b0) begin
      failed++;
      $display("FAIL flush_hazard_stall: id_stall=%b want 0", bus.id_stall);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_addi();
    test_bypass();
    test_rtype_ops();
    test_load_use();
    test_hold();
    test_flush_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
